// File: rtl/led_trail_pwm.sv
// led_trail_pwm: per-LED afterglow brightness (load on pattern, stepwise decay) rendered by a shared PWM counter.
// Build macro LED_TRAIL_GAMMA_EN switches the duty mapping from linear to a square-law curve.
module led_trail_lane #(
  parameter int LEVEL_BITS = 4
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  tick_i,
  input  logic [LEVEL_BITS-1:0] pwm_i,
  output logic                  led_o
);
  localparam logic [LEVEL_BITS-1:0] MAX = '1;

  logic [LEVEL_BITS-1:0] bri_q, bri_d, eff;
  logic                  led_q;

`ifdef LED_TRAIL_GAMMA_EN
  logic [2*LEVEL_BITS-1:0] sq;
  always_comb begin
    sq  = {{LEVEL_BITS{1'b0}}, bri_q} * {{LEVEL_BITS{1'b0}}, bri_q};
    // Full scale stays full so a held pattern bit keeps the LED solidly on.
    eff = (bri_q == MAX) ? MAX : LEVEL_BITS'(sq >> LEVEL_BITS);
  end
`else
  assign eff = bri_q;
`endif

  always_comb begin
    bri_d = bri_q;
    if (load_i)                     bri_d = MAX;
    else if (tick_i && bri_q != '0) bri_d = bri_q - 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      bri_q <= '0;
      led_q <= 1'b0;
    end else begin
      bri_q <= bri_d;
      led_q <= (pwm_i < eff);
    end
  end

  assign led_o = led_q;
endmodule

module led_trail_pwm #(
  parameter int WIDTH      = 8,
  parameter int LEVEL_BITS = 4,
  parameter int DECAY_DIV  = 1000000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] led_out
);
  localparam int DIV_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [LEVEL_BITS-1:0] PWM_LAST = {{(LEVEL_BITS-1){1'b1}}, 1'b0};

  logic [DIV_W-1:0]      dcnt_q, dcnt_d;
  logic [LEVEL_BITS-1:0] pwm_q, pwm_d;
  logic                  decay_tick;

  assign decay_tick = (dcnt_q == DIV_W'(DECAY_DIV - 1));

  // PWM period is MAX cycles (0..MAX-1) so level MAX is solid on and level b gives b highs.
  always_comb begin
    dcnt_d = decay_tick ? '0 : dcnt_q + 1'b1;
    pwm_d  = (pwm_q == PWM_LAST) ? '0 : pwm_q + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      dcnt_q <= '0;
      pwm_q  <= '0;
    end else begin
      dcnt_q <= dcnt_d;
      pwm_q  <= pwm_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    led_trail_lane #(.LEVEL_BITS(LEVEL_BITS)) u_lane (
      .clk_in (clk_in),
      .reset  (reset),
      .load_i (pattern[g]),
      .tick_i (decay_tick),
      .pwm_i  (pwm_q),
      .led_o  (led_out[g])
    );
  end
endmodule
